// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO multiply/divide unit for the EX stage
module hilo_muldiv_unit #(
  parameter int DATA_W   = 32,
  parameter int DIV_ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o
);

  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MTLO  = 8'h13;

  localparam int CNT_W = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_opa;      // multiplicand, or dividend shifting into quotient
  logic [DATA_W-1:0] r_opb;      // multiplier, or divisor magnitude
  logic [DATA_W-1:0] r_rem;      // partial remainder
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mul_sgn;
  logic              r_neg_q;
  logic              r_neg_r;

  logic              w_is_mul;
  logic              w_is_div;
  logic              w_is_mt;
  logic              w_accept;
  logic              w_div_zero;
  logic              w_sgn_div;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;
  logic [2*DATA_W-1:0] w_mul_a;
  logic [2*DATA_W-1:0] w_mul_b;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W:0]   w_trial;    // shifted remainder with carry bit for the trial subtract
  logic [DATA_W:0]   w_diff;
  logic              w_ge;

  assign w_is_mul   = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);
  assign w_is_div   = (aluop_i == OP_DIV)  || (aluop_i == OP_DIVU);
  assign w_is_mt    = (aluop_i == OP_MTHI) || (aluop_i == OP_MTLO);
  assign w_accept   = (r_state == S_IDLE) && valid_i && !flush_i && (w_is_mul || w_is_div || w_is_mt);
  assign w_div_zero = (src_b_i == '0);
  assign w_sgn_div  = (aluop_i == OP_DIV);
  assign w_abs_a    = (w_sgn_div && src_a_i[DATA_W-1]) ? (~src_a_i + 1'b1) : src_a_i;
  assign w_abs_b    = (w_sgn_div && src_b_i[DATA_W-1]) ? (~src_b_i + 1'b1) : src_b_i;

  // Sign-extending to full width lets a plain unsigned multiply give the right low 64 bits.
  assign w_mul_a = {{DATA_W{r_mul_sgn & r_opa[DATA_W-1]}}, r_opa};
  assign w_mul_b = {{DATA_W{r_mul_sgn & r_opb[DATA_W-1]}}, r_opb};
  assign w_prod  = w_mul_a * w_mul_b;

  assign w_trial = {r_rem, r_opa[DATA_W-1]};
  assign w_diff  = w_trial - {1'b0, r_opb};
  assign w_ge    = !w_diff[DATA_W];

  assign busy_o = (r_state != S_IDLE);

  // Next-state and stall; a flush forces IDLE and drops the stall.
  always_comb begin
    w_next  = r_state;
    stall_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_next  = S_MUL;
          stall_o = 1'b1;
        end else if (w_accept && w_is_div && !w_div_zero) begin
          w_next  = S_DIV;
          stall_o = 1'b1;
        end
      end
      S_MUL: w_next = S_IDLE;
      S_DIV: begin
        stall_o = 1'b1;
        if (r_cnt == CNT_LAST) w_next = S_FIX;
      end
      S_FIX: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i) begin
      w_next  = S_IDLE;
      stall_o = 1'b0;
    end
  end

  // State, operand datapath and HI/LO writes at the completion points only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      hi_o      <= '0;
      lo_o      <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_mul_sgn <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (aluop_i == OP_MTHI) hi_o <= src_a_i;
            if (aluop_i == OP_MTLO) lo_o <= src_a_i;
            if (w_is_mul) begin
              r_opa     <= src_a_i;
              r_opb     <= src_b_i;
              r_mul_sgn <= (aluop_i == OP_MULT);
            end
            if (w_is_div && !w_div_zero) begin
              r_opa   <= w_abs_a;
              r_opb   <= w_abs_b;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_neg_q <= w_sgn_div && (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
              r_neg_r <= w_sgn_div && src_a_i[DATA_W-1];
            end
          end
        end
        S_MUL: begin
          if (!flush_i) begin
            hi_o <= w_prod[2*DATA_W-1:DATA_W];
            lo_o <= w_prod[DATA_W-1:0];
          end
        end
        S_DIV: begin
          if (!flush_i) begin
            r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
            r_opa <= {r_opa[DATA_W-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!flush_i) begin
            lo_o <= r_neg_q ? (~r_opa + 1'b1) : r_opa;
            hi_o <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        valid_i;
  logic [7:0]  aluop_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  int          exp_stall;
  int          got_stall;
  int          busy_rises = 0;
  logic        busy_d = 1'b0;

  localparam logic [7:0] MULT = 8'h18, MULTU = 8'h19, DIV = 8'h1A, DIVU = 8'h1B,
                         MTHI = 8'h11, MTLO = 8'h13;

  hilo_muldiv_unit #(.DATA_W(32), .DIV_ITER(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .aluop_i(aluop_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .stall_o(stall_o), .hi_o(hi_o),
    .lo_o(lo_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy_o && !busy_d) busy_rises++;
    busy_d = busy_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Architectural reference: what HI/LO hold after the op and how long it stalls.
  task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    exp_stall = 0;
    sa = a;
    sb = b;
    case (op)
      MTHI: exp_hi = a;
      MTLO: exp_lo = a;
      MULT: begin
        sp = longint'(sa) * longint'(sb);
        {exp_hi, exp_lo} = sp;
        exp_stall = 1;
      end
      MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        {exp_hi, exp_lo} = up;
        exp_stall = 1;
      end
      DIV: if (b != 0) begin
        exp_stall = 33;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          exp_lo = 32'h8000_0000;
          exp_hi = 32'h0;
        end else begin
          exp_lo = sa / sb;
          exp_hi = sa % sb;
        end
      end
      DIVU: if (b != 0) begin
        exp_stall = 33;
        exp_lo = a / b;
        exp_hi = a % b;
      end
      default: ;
    endcase
  endtask

  // Hold the instruction in EX while stall_o is high, as the pipeline would.
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic s;
    int   guard;
    valid_i = 1'b1;
    aluop_i = op;
    src_a_i = a;
    src_b_i = b;
    got_stall = 0;
    guard = 0;
    forever begin
      @(negedge clk);
      s = stall_o;
      if (s) got_stall++;
      @(posedge clk);
      #1;
      if (!s) break;
      guard++;
      if (guard > 100) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout: observed stall beyond 100 cycles, required at most 33");
        break;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    model(op, a, b);
    issue(op, a, b);
    chk({tag, "_stall"}, 32'(got_stall), 32'(exp_stall));
    chk({tag, "_hi"}, hi_o, exp_hi);
    chk({tag, "_lo"}, lo_o, exp_lo);
  endtask

  initial begin
    logic [7:0]  ops [9];
    logic [31:0] ra, rb;
    logic [7:0]  rop;
    ops = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO, 8'h00, 8'h10, 8'h12};

    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; aluop_i = '0; src_a_i = '0; src_b_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    exp_hi = '0;
    exp_lo = '0;
    @(posedge clk);
    #1;

    run_op("mthi", MTHI, 32'h1234_5678, 32'h0);
    run_op("mtlo", MTLO, 32'h9ABC_DEF0, 32'h0);
    chk("mt_keep_hi", hi_o, 32'h1234_5678);

    run_op("mult", MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi_const", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo_o, 32'hFFFF_FFFA);
    run_op("multu", MULTU, 32'hFFFF_FFFE, 32'd3);
    chk("multu_hi_const", hi_o, 32'h0000_0002);

    run_op("div", DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_const", lo_o, 32'hFFFF_FFFD);
    chk("div_hi_const", hi_o, 32'hFFFF_FFFF);
    run_op("divu", DIVU, 32'd7, 32'd2);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_const", lo_o, 32'h8000_0000);

    run_op("pre_hi", MTHI, 32'h55, 32'h0);
    run_op("pre_lo", MTLO, 32'h55, 32'h0);
    run_op("div0", DIV, 32'h1234, 32'h0);
    run_op("divu0", DIVU, 32'h1234, 32'h0);
    chk("div0_busy", {31'h0, busy_o}, 32'h0);

    // Flush in T10 of a DIV.
    valid_i = 1'b1; aluop_i = DIV; src_a_i = 32'd100; src_b_i = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    chk("flush_pre_stall", {31'h0, stall_o}, 32'h1);
    flush_i = 1'b1;
    #1;
    chk("flush_stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("flush_busy", {31'h0, busy_o}, 32'h0);
    @(posedge clk);
    #1;
    chk("flush_hi", hi_o, 32'h55);
    chk("flush_lo", lo_o, 32'h55);

    // Reset in T20 of a second DIV.
    valid_i = 1'b1; aluop_i = DIV; src_a_i = 32'd1000; src_b_i = 32'd3;
    repeat (20) @(posedge clk);
    #1;
    chk("rstmid_busy_pre", {31'h0, busy_o}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_i = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    chk("rstmid_hi", hi_o, 32'h0);
    chk("rstmid_lo", lo_o, 32'h0);
    chk("rstmid_busy", {31'h0, busy_o}, 32'h0);

    // Back-to-back MULT then DIVU; exactly two multi-cycle accepts.
    busy_rises = 0;
    run_op("b2b_mult", MULT, 32'h0000_1234, 32'hFFFF_0000);
    run_op("b2b_divu", DIVU, 32'hDEAD_BEEF, 32'h0000_0123);
    @(posedge clk);
    #1;
    chk("b2b_accepts", 32'(busy_rises), 32'd2);
    chk("b2b_final_hi", hi_o, 32'hDEAD_BEEF % 32'h123);
    chk("b2b_final_lo", lo_o, 32'hDEAD_BEEF / 32'h123);

    // Randomised ops, including unsupported opcodes and edge operands.
    for (int i = 0; i < 60; i++) begin
      rop = ops[$urandom_range(0, 8)];
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 15);
        3: ra = 32'h8000_0000;
        4: ra = $urandom_range(0, 100);
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%02h", i, rop), rop, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
